multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle RV32I-subset CPU.
- Steps the shared datapath (PC, IR, register file, ALU, unified memory) through fetch, decode, execute, memory and writeback.
- Drives every datapath strobe and the 2-bit op field consumed by the ALU control block.
- Stalls on a memory ready handshake and counts retired instructions.

---
 rtl/multicycle_main_control.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Main control FSM of the multicycle RV32I-subset CPU. It steps the shared
// datapath through fetch, decode, execute, memory and writeback. It stalls on
// the memory ready handshake and counts retired instructions.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an unsupported opcode enters TRAP. TRAP raises illegal_insn
//               and stays there until reset.
//   undefined : an unsupported opcode is treated as a NOP. illegal_insn is 0.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   opcode          IR[6:0], valid from DECODE onward
//   mem_ready       memory completes the current read/write this cycle
//   pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write,
//   ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, op
//                   datapath strobes, selects and the ALU control op field
//   state_dbg       current state encoding
//   retired_count   retired-instruction counter, wraps
//   illegal_insn    trap flag
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 on mem_ready
// DECODE    | dispatch on opcode, precompute branch target
// MEM_ADDR  | rs1 + imm effective address
// MEM_READ  | load data request, wait for mem_ready
// MEM_WB    | write MDR to rd
// MEM_WRITE | store data request, wait for mem_ready
// EXECUTE   | R/I-type ALU operation
// ALU_WB    | write ALUOut to rd
// BRANCH    | compare rs1/rs2, conditional PC load from ALUOut
// TRAP      | illegal instruction, held until reset

module multicycle_main_control #(
    parameter int COUNT_W = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               pc_source,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         op,
    output logic [STATE_W-1:0] state_dbg,
    output logic [COUNT_W-1:0] retired_count,
    output logic               illegal_insn
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q;
    logic               retire;

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        op            = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_RTYPE, OPC_ITYPE: state_d = S_EXECUTE;
                    OPC_BRANCH:           state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:              state_d = S_TRAP;
`else
                    default:              state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                op        = 2'b10;
                alu_src_b = (opcode == OPC_ITYPE) ? 2'b10 : 2'b00;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                op            = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase

        // Reset aborts the current instruction: no strobe may fire in the reset cycle.
        if (!rst_n) begin
            state_d       = S_FETCH;
            retire        = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            ior_d         = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            op            = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + COUNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end

    assign illegal_insn = illegal_q;
`else
    assign illegal_insn = 1'b0;
`endif

    assign state_dbg     = STATE_W'(state_q);
    assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, pc_source, ior_d;
    logic        mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, op;
    logic [3:0]  state_dbg;
    logic [31:0] retired_count;
    logic        illegal_insn;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_count = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.COUNT_W(32), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .op(op),
        .state_dbg(state_dbg), .retired_count(retired_count),
        .illegal_insn(illegal_insn)
    );

    // Advance to the next negedge, drive, and settle before sampling.
    task automatic cyc(input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; opcode = 7'b0; mem_ready = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        n_checks++;
        if (state_dbg !== 4'd0 || retired_count !== 32'd0 || illegal_insn !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d count=%0d illegal=%b required 0/0/0",
                     state_dbg, retired_count, illegal_insn);
        end
        n_checks++;
        if (mem_read !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_strobes: mem_read=%b ir_write=%b pc_write=%b required 0",
                     mem_read, ir_write, pc_write);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_mid_write_reset;
        opcode = 7'b0100011;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        n_checks++;
        if (state_dbg !== 4'd5 || mem_write !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_prewrite: state=%0d mem_write=%b required 5/1", state_dbg, mem_write);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || ior_d !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_strobe: mem_write=%b ior_d=%b required 0/0", mem_write, ior_d);
        end
        cyc(1'b0);
        cyc(1'b0);
        n_checks++;
        if (state_dbg !== 4'd0 || retired_count !== 32'd0 || mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_after: state=%0d count=%0d mem_write=%b required 0/0/0",
                     state_dbg, retired_count, mem_write);
        end
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_alu(input logic [6:0] opc, input logic [1:0] exp_b);
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = opc;
        for (int i = 0; i < 5; i++) begin
            cyc(i != 4);
            n_checks++;
            if (state_dbg !== exp_st[i]) begin
                n_errors++;
                $display("FAIL alu_state[%0d]: got %0d required %0d", i, state_dbg, exp_st[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (op !== 2'b10 || alu_src_b !== exp_b || alu_src_a !== 1'b1) begin
                    n_errors++;
                    $display("FAIL alu_execute: op=%b src_b=%b src_a=%b required 10/%b/1",
                             op, alu_src_b, alu_src_a, exp_b);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin
                    n_errors++;
                    $display("FAIL alu_wb: reg_write=%b mem_to_reg=%b required 1/0", reg_write, mem_to_reg);
                end
            end
        end
        exp_count = exp_count + 1;
        n_checks++;
        if (retired_count !== exp_count) begin
            n_errors++;
            $display("FAIL alu_count: got %0d required %0d", retired_count, exp_count);
        end
    endtask

    task automatic test_load_stall;
        logic [3:0] exp_st [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       mr     [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            cyc(mr[i]);
            n_checks++;
            if (state_dbg !== exp_st[i]) begin
                n_errors++;
                $display("FAIL load_state[%0d]: got %0d required %0d", i, state_dbg, exp_st[i]);
            end
            if (i == 1) begin
                n_checks++;
                if (alu_src_b !== 2'b11 || alu_src_a !== 1'b0 || op !== 2'b00) begin
                    n_errors++;
                    $display("FAIL decode_out: src_b=%b src_a=%b op=%b required 11/0/00",
                             alu_src_b, alu_src_a, op);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin
                    n_errors++;
                    $display("FAIL mem_addr: src_a=%b src_b=%b required 1/10", alu_src_a, alu_src_b);
                end
            end
            if (i >= 3 && i <= 6) begin
                n_checks++;
                if (mem_read !== 1'b1 || ior_d !== 1'b1) begin
                    n_errors++;
                    $display("FAIL load_hold[%0d]: mem_read=%b ior_d=%b required 1/1", i, mem_read, ior_d);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (mem_to_reg !== 1'b1 || reg_write !== 1'b1) begin
                    n_errors++;
                    $display("FAIL load_wb: mem_to_reg=%b reg_write=%b required 1/1", mem_to_reg, reg_write);
                end
            end
        end
        exp_count = exp_count + 1;
        n_checks++;
        if (retired_count !== exp_count) begin
            n_errors++;
            $display("FAIL load_count: got %0d required %0d", retired_count, exp_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] st_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        logic [3:0] st_b [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        int         writes = 0;
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            cyc(i != 4);
            if (mem_write === 1'b1) writes++;
            n_checks++;
            if (state_dbg !== st_s[i]) begin
                n_errors++;
                $display("FAIL store_state[%0d]: got %0d required %0d", i, state_dbg, st_s[i]);
            end
        end
        n_checks++;
        if (writes != 1) begin
            n_errors++;
            $display("FAIL store_writes: got %0d required 1", writes);
        end
        opcode = 7'b1100011;
        for (int i = 0; i < 4; i++) begin
            cyc(i != 3);
            n_checks++;
            if (state_dbg !== st_b[i]) begin
                n_errors++;
                $display("FAIL branch_state[%0d]: got %0d required %0d", i, state_dbg, st_b[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (op !== 2'b01 || pc_write_cond !== 1'b1 || pc_source !== 1'b1 ||
                    alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || reg_write !== 1'b0) begin
                    n_errors++;
                    $display("FAIL branch_out: op=%b pwc=%b psrc=%b src_a=%b src_b=%b rw=%b required 01/1/1/1/00/0",
                             op, pc_write_cond, pc_source, alu_src_a, alu_src_b, reg_write);
                end
            end
        end
        exp_count = exp_count + 2;
        n_checks++;
        if (retired_count !== exp_count) begin
            n_errors++;
            $display("FAIL store_branch_count: got %0d required %0d", retired_count, exp_count);
        end
    endtask

    task automatic test_fetch_stall;
        logic [3:0] exp_st [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic       mr     [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_ld [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0110011;
        for (int i = 0; i < 7; i++) begin
            cyc(mr[i]);
            n_checks++;
            if (state_dbg !== exp_st[i] || ir_write !== exp_ld[i] || pc_write !== exp_ld[i]) begin
                n_errors++;
                $display("FAIL fetch_stall[%0d]: state=%0d ir_write=%b pc_write=%b required %0d/%b/%b",
                         i, state_dbg, ir_write, pc_write, exp_st[i], exp_ld[i], exp_ld[i]);
            end
        end
        exp_count = exp_count + 1;
        n_checks++;
        if (retired_count !== exp_count) begin
            n_errors++;
            $display("FAIL fetch_stall_count: got %0d required %0d", retired_count, exp_count);
        end
    endtask

    task automatic test_illegal;
        opcode = 7'b1111111;
        cyc(1'b1);
        cyc(1'b1);
        n_checks++;
        if (state_dbg !== 4'd1) begin
            n_errors++;
            $display("FAIL illegal_decode: state=%0d required 1", state_dbg);
        end
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            n_checks++;
            if (state_dbg !== 4'd9 || illegal_insn !== 1'b1 || mem_read !== 1'b0 ||
                pc_write !== 1'b0 || retired_count !== exp_count) begin
                n_errors++;
                $display("FAIL trap_hold[%0d]: state=%0d illegal=%b mem_read=%b pc_write=%b count=%0d required 9/1/0/0/%0d",
                         i, state_dbg, illegal_insn, mem_read, pc_write, retired_count, exp_count);
            end
        end
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0;
        cyc(1'b0);
        rst_n = 1'b1;
        exp_count = 0;
        n_checks++;
        if (state_dbg !== 4'd0 || illegal_insn !== 1'b0 || retired_count !== exp_count) begin
            n_errors++;
            $display("FAIL trap_reset: state=%0d illegal=%b count=%0d required 0/0/0",
                     state_dbg, illegal_insn, retired_count);
        end
`else
        cyc(1'b0);
        n_checks++;
        if (state_dbg !== 4'd0 || illegal_insn !== 1'b0 || retired_count !== exp_count) begin
            n_errors++;
            $display("FAIL illegal_nop: state=%0d illegal=%b count=%0d required 0/0/%0d",
                     state_dbg, illegal_insn, retired_count, exp_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mid_write_reset();
        test_alu(7'b0110011, 2'b00);
        test_alu(7'b0010011, 2'b10);
        test_load_stall();
        test_back_to_back();
        test_fetch_stall();
        test_illegal();
        test_alu(7'b0110011, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
